// File: rtl/bpb_update_ctrl.sv
// -----------------------------------------------------------------------------
// bpb_update_ctrl
//
// Decouples branch resolution in EX from the branch-prediction-buffer (BPB)
// write port. Resolved branches are pushed into a small FIFO and drained to the
// BPB whenever the write port is free and the pipeline is not stalled. In
// parallel, each accepted resolve is compared against the prediction made for
// it. A wrong direction, or a wrong target for a correctly predicted taken
// branch, raises a one-cycle fetch redirect and bumps a saturating counter.
//
// Ports
//   clk_i              clock, all state updates on the rising edge
//   rst_i              asynchronous reset, active low
//   stall_i            pipeline stall, blocks draining
//   flush_i            pipeline flush, blocks accepting (queued entries kept)
//   resolve_valid_i    EX presents a resolved branch
//   resolve_pc_i       branch PC
//   resolve_target_i   resolved target
//   resolve_taken_i    resolved direction
//   pred_taken_i       predicted direction
//   pred_addr_i        predicted target
//   resolve_ready_o    queue can accept a resolve this cycle
//   upd_valid_o        BPB write request valid (head of queue)
//   upd_pc_o           head entry PC
//   upd_taken_o        head entry direction
//   upd_target_o       head entry target
//   upd_ready_i        BPB write port free this cycle
//   mispredict_o       one-cycle redirect pulse
//   redirect_addr_o    fetch redirect address
//   full_o / empty_o   queue occupancy flags
//   mispredict_cnt_o   saturating mispredict count
// -----------------------------------------------------------------------------
module bpb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        resolve_valid_i,
  input  logic [31:0] resolve_pc_i,
  input  logic [31:0] resolve_target_i,
  input  logic        resolve_taken_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_addr_i,
  output logic        resolve_ready_o,
  output logic        upd_valid_o,
  output logic [31:0] upd_pc_o,
  output logic        upd_taken_o,
  output logic [31:0] upd_target_o,
  input  logic        upd_ready_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_addr_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [15:0] mispredict_cnt_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic               r_mispredict;
  logic [31:0]        r_redirect_addr;
  logic [15:0]        r_mispredict_cnt;

  logic               w_push;
  logic               w_pop;
  logic               w_mispredict;
  entry_t             w_head;

  // Flags come from the registered count only, so ready never depends on a
  // same-cycle pop.
  assign empty_o         = (r_count == '0);
  assign full_o          = (r_count == (PTR_W+1)'(DEPTH));
  assign resolve_ready_o = !full_o && !flush_i;
  assign upd_valid_o     = !empty_o && !stall_i;

  assign w_push = resolve_valid_i && resolve_ready_o;
  assign w_pop  = upd_valid_o && upd_ready_i;

  // Target only matters when both resolution and prediction say taken.
  assign w_mispredict = (resolve_taken_i != pred_taken_i) ||
                        (resolve_taken_i && pred_taken_i &&
                         (resolve_target_i != pred_addr_i));

  assign w_head       = r_mem[r_head];
  assign upd_pc_o     = w_head.pc;
  assign upd_taken_o  = w_head.taken;
  assign upd_target_o = w_head.target;

  assign mispredict_o     = r_mispredict;
  assign redirect_addr_o  = r_redirect_addr;
  assign mispredict_cnt_o = r_mispredict_cnt;

  // NOTE: entry storage has no reset; validity is tracked solely by the
  // pointers and count, so clearing it would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_tail] <= '{pc: resolve_pc_i, taken: resolve_taken_i,
                         target: resolve_target_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Redirect path is independent of stall: it reacts to acceptance only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mispredict     <= 1'b0;
      r_redirect_addr  <= 32'h0;
      r_mispredict_cnt <= 16'h0;
    end else begin
      r_mispredict <= w_push && w_mispredict;
      if (w_push && w_mispredict) begin
        r_redirect_addr <= resolve_taken_i ? resolve_target_i
                                           : (resolve_pc_i + 32'd4);
        if (r_mispredict_cnt != 16'hFFFF) begin
          r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpb_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bpb_update_ctrl
//
// Directed stimulus against bpb_update_ctrl. A queue-based reference model
// tracks the expected contents and redirect state; a compare process checks
// all outputs on every falling edge, and the directed sequence adds literal
// expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_bpb_update_ctrl;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        resolve_valid_i = 1'b0;
  logic [31:0] resolve_pc_i = '0;
  logic [31:0] resolve_target_i = '0;
  logic        resolve_taken_i = 1'b0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_addr_i = '0;
  logic        resolve_ready_o;
  logic        upd_valid_o;
  logic [31:0] upd_pc_o;
  logic        upd_taken_o;
  logic [31:0] upd_target_o;
  logic        upd_ready_i = 1'b0;
  logic        mispredict_o;
  logic [31:0] redirect_addr_o;
  logic        full_o;
  logic        empty_o;
  logic [15:0] mispredict_cnt_o;

  bpb_update_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_pc_i     (resolve_pc_i),
    .resolve_target_i (resolve_target_i),
    .resolve_taken_i  (resolve_taken_i),
    .pred_taken_i     (pred_taken_i),
    .pred_addr_i      (pred_addr_i),
    .resolve_ready_o  (resolve_ready_o),
    .upd_valid_o      (upd_valid_o),
    .upd_pc_o         (upd_pc_o),
    .upd_taken_o      (upd_taken_o),
    .upd_target_o     (upd_target_o),
    .upd_ready_i      (upd_ready_i),
    .mispredict_o     (mispredict_o),
    .redirect_addr_o  (redirect_addr_o),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic        m_mis = 1'b0;
  logic [31:0] m_redir = '0;
  int          m_cnt = 0;
  bit          m_acc, m_pop, m_mp;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mq.delete();
      m_mis   = 1'b0;
      m_redir = '0;
      m_cnt   = 0;
    end else begin
      m_acc = resolve_valid_i && !flush_i && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && !stall_i && upd_ready_i;
      m_mp  = m_acc && ((resolve_taken_i != pred_taken_i) ||
                        (resolve_taken_i && resolve_target_i != pred_addr_i));
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back('{resolve_pc_i, resolve_taken_i, resolve_target_i});
      m_mis = m_mp;
      if (m_mp) begin
        m_redir = resolve_taken_i ? resolve_target_i : resolve_pc_i + 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("m_empty", 32'(empty_o), 32'(mq.size() == 0));
      check("m_full", 32'(full_o), 32'(mq.size() == DEPTH));
      check("m_ready", 32'(resolve_ready_o), 32'(mq.size() < DEPTH && !flush_i));
      check("m_uvalid", 32'(upd_valid_o), 32'(mq.size() > 0 && !stall_i));
      if (mq.size() > 0) begin
        check("m_upc", upd_pc_o, mq[0].pc);
        check("m_utaken", 32'(upd_taken_o), 32'(mq[0].taken));
        check("m_utgt", upd_target_o, mq[0].tgt);
      end
      check("m_mis", 32'(mispredict_o), 32'(m_mis));
      check("m_redir", redirect_addr_o, m_redir);
      check("m_cnt", 32'(mispredict_cnt_o), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] paddr);
    resolve_valid_i  = 1'b1;
    resolve_pc_i     = pc;
    resolve_taken_i  = tk;
    resolve_target_i = tgt;
    pred_taken_i     = ptk;
    pred_addr_i      = paddr;
    cyc();
    resolve_valid_i  = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) cyc();
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_uvalid", 32'(upd_valid_o), 32'd0);
    check("rst_mis", 32'(mispredict_o), 32'd0);
    check("rst_redir", redirect_addr_o, 32'h0);
    check("rst_cnt", 32'(mispredict_cnt_o), 32'd0);
    rst_i  = 1'b1;
    chk_en = 1'b1;
    cyc();

    // single correctly predicted push, drained next cycle
    upd_ready_i = 1'b1;
    push(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    check("t1_uvalid", 32'(upd_valid_o), 32'd1);
    check("t1_upc", upd_pc_o, 32'h100);
    check("t1_utgt", upd_target_o, 32'h200);
    check("t1_mis", 32'(mispredict_o), 32'd0);
    cyc();
    check("t1_empty", 32'(empty_o), 32'd1);

    // back-to-back pushes with concurrent pop (count holds)
    push(32'h110, 1'b0, 32'h0, 1'b0, 32'h0);
    push(32'h114, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1b_upc", upd_pc_o, 32'h114);
    cyc();
    check("t1b_empty", 32'(empty_o), 32'd1);

    // fill the queue, fifth push ignored, ordered drain
    upd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h1000 + 32'(i * 4), 1'(i), 32'h2000 + 32'(i), 1'(i), 32'h2000 + 32'(i));
    check("t2_full", 32'(full_o), 32'd1);
    check("t2_ready", 32'(resolve_ready_o), 32'd0);
    push(32'h5555, 1'b0, 32'h0, 1'b1, 32'h0);
    check("t2_full5", 32'(full_o), 32'd1);
    check("t2_cnt5", 32'(mispredict_cnt_o), 32'd0);
    check("t2_mis5", 32'(mispredict_o), 32'd0);
    upd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_uvalid", 32'(upd_valid_o), 32'd1);
      check("t2_upc", upd_pc_o, 32'h1000 + 32'(i * 4));
      cyc();
    end
    check("t2_empty", 32'(empty_o), 32'd1);

    // direction mispredict, pc + 4 wraps to zero
    push(32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678);
    check("t3_mis", 32'(mispredict_o), 32'd1);
    check("t3_redir", redirect_addr_o, 32'h0000_0000);
    check("t3_cnt", 32'(mispredict_cnt_o), 32'd1);
    cyc();
    check("t3_mis_off", 32'(mispredict_o), 32'd0);

    // target mispredict while stalled
    stall_i = 1'b1;
    push(32'h400, 1'b1, 32'h300, 1'b1, 32'h304);
    check("t4_mis", 32'(mispredict_o), 32'd1);
    check("t4_redir", redirect_addr_o, 32'h300);
    check("t4_cnt", 32'(mispredict_cnt_o), 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("t4_uvalid_stall", 32'(upd_valid_o), 32'd0);
      check("t4_nempty", 32'(empty_o), 32'd0);
      cyc();
    end
    stall_i = 1'b0;
    #1;
    check("t4_uvalid", 32'(upd_valid_o), 32'd1);
    check("t4_upc", upd_pc_o, 32'h400);
    cyc();
    check("t4_empty", 32'(empty_o), 32'd1);

    // flush blocks acceptance but keeps queued entries
    upd_ready_i = 1'b0;
    push(32'h600, 1'b1, 32'h700, 1'b1, 32'h700);
    push(32'h604, 1'b0, 32'h0, 1'b0, 32'h0);
    flush_i          = 1'b1;
    resolve_valid_i  = 1'b1;
    resolve_pc_i     = 32'h800;
    resolve_taken_i  = 1'b1;
    resolve_target_i = 32'h900;
    pred_taken_i     = 1'b0;
    #1;
    check("t5_ready", 32'(resolve_ready_o), 32'd0);
    repeat (2) cyc();
    check("t5_mis", 32'(mispredict_o), 32'd0);
    check("t5_cnt", 32'(mispredict_cnt_o), 32'd2);
    flush_i         = 1'b0;
    resolve_valid_i = 1'b0;
    upd_ready_i     = 1'b1;
    #1;
    check("t5_upc0", upd_pc_o, 32'h600);
    cyc();
    check("t5_upc1", upd_pc_o, 32'h604);
    cyc();
    check("t5_empty", 32'(empty_o), 32'd1);

    // asynchronous reset mid-drain
    upd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hA00 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0);
    upd_ready_i = 1'b1;
    cyc();
    #3;
    rst_i = 1'b0;
    #1;
    check("t6_empty", 32'(empty_o), 32'd1);
    check("t6_full", 32'(full_o), 32'd0);
    check("t6_uvalid", 32'(upd_valid_o), 32'd0);
    check("t6_redir", redirect_addr_o, 32'h0);
    check("t6_cnt", 32'(mispredict_cnt_o), 32'd0);
    repeat (2) cyc();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_post_uvalid", 32'(upd_valid_o), 32'd0);
      check("t6_post_empty", 32'(empty_o), 32'd1);
    end

    @(negedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpb_update_ctrl.md
BPB_UPDATE_CTRL -- requirements
Module: bpb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update-queue entries (power of two, >=2).
REQ-002 SHALL have parameter PTR_W, default 2, meaning log2(DEPTH).
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port stall_i  input  1  meaning pipeline stall; while high, the queue SHALL not drain.
REQ-006 SHALL have port flush_i  input  1  meaning pipeline flush; while high, the queue SHALL not accept resolves.
REQ-007 SHALL have port resolve_valid_i  input  1  meaning EX stage presents a resolved branch.
REQ-008 SHALL have ports resolve_pc_i / resolve_target_i  input  32 each  meaning branch PC / resolved target.
REQ-009 SHALL have port resolve_taken_i  input  1  meaning resolved direction.
REQ-010 SHALL have ports pred_taken_i  input  1 and pred_addr_i  input  32  meaning the prediction made for this branch.
REQ-011 SHALL have port resolve_ready_o  output  1  meaning the queue can accept a resolve this cycle.
REQ-012 SHALL have ports upd_valid_o  output  1, upd_pc_o  output  32, upd_taken_o  output  1, upd_target_o  output  32  meaning the BPB write request (head of queue).
REQ-013 SHALL have port upd_ready_i  input  1  meaning the BPB write port is free this cycle.
REQ-014 SHALL have ports mispredict_o  output  1 and redirect_addr_o  output  32  meaning fetch redirect request.
REQ-015 SHALL have ports full_o, empty_o  output  1 each, and mispredict_cnt_o  output  16  meaning the mispredict count.

Function
REQ-016 Accept: a resolve SHALL be accepted when resolve_valid_i & resolve_ready_o; resolve_ready_o SHALL equal !full_o & !flush_i (no same-cycle pop bypass).
REQ-017 An accepted resolve SHALL be written at the tail; the tail pointer SHALL increment modulo DEPTH.
REQ-018 Drain: a pop SHALL occur when upd_valid_o & upd_ready_i; the head pointer SHALL increment modulo DEPTH.
REQ-019 upd_valid_o SHALL equal !empty_o & !stall_i; upd_pc_o/upd_taken_o/upd_target_o SHALL be the head entry, held stable until popped.
REQ-020 Latency: an entry accepted in cycle N into an empty queue SHALL appear on upd_* in cycle N+1 at the earliest.
REQ-021 The occupancy count (PTR_W+1 bits) SHALL increment on push-only, decrement on pop-only, and hold on push+pop in the same cycle.
REQ-022 full_o SHALL be high when count==DEPTH; empty_o SHALL be high when count==0; both SHALL derive from registered state only.
REQ-023 Mispredict: an accepted resolve SHALL be mispredicted iff (resolve_taken_i != pred_taken_i) or (resolve_taken_i & pred_taken_i & resolve_target_i != pred_addr_i).
REQ-024 mispredict_o SHALL be a registered, one-cycle pulse in cycle N+1 for a mispredicted accept in cycle N, independent of stall_i.
REQ-025 redirect_addr_o SHALL register resolve_target_i if resolve_taken_i, else resolve_pc_i + 4 (32-bit, wraps modulo 2^32); it SHALL update only on a mispredicted accept.
REQ-026 Non-accepted resolves (valid low, full, or flush high) SHALL affect neither the queue, mispredict_o nor the counter.
REQ-027 mispredict_cnt_o SHALL increment by 1 per mispredicted accept and saturate at 16'hFFFF.
REQ-028 flush_i SHALL NOT discard queued entries (they are older, committed branches); only acceptance is blocked.

Reset
REQ-029 While rst_i is low: head, tail, count = 0; empty_o = 1; full_o = 0; upd_valid_o = 0; mispredict_o = 0; redirect_addr_o = 32'h0; mispredict_cnt_o = 0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries immediately; entry storage need not be cleared.

Verification
REQ-031 Push pc=0x100, taken=1, target=0x200, pred_taken=1, pred_addr=0x200 with upd_ready_i=1 -> upd_valid_o high next cycle with pc 0x100/target 0x200; mispredict_o stays 0; count returns to 0.
REQ-032 upd_ready_i=0, push 4 entries -> full_o=1, resolve_ready_o=0; 5th push ignored; release upd_ready_i -> entries drain in order over 4 cycles, then empty_o=1.
REQ-033 Accept pc=0xFFFFFFFC, taken=0, pred_taken=1 -> next cycle mispredict_o=1 for one cycle, redirect_addr_o=0x00000000, mispredict_cnt_o=1.
REQ-034 Accept taken=1, pred_taken=1, target=0x300, pred_addr=0x304 -> mispredict_o pulse, redirect_addr_o=0x300; with stall_i=1 held, upd_valid_o=0 and the entry remains queued.
REQ-035 Queue holds 2 entries, flush_i=1 with resolve_valid_i=1 -> no accept, no mispredict pulse, 2 entries still drain after flush.
REQ-036 Queue holds 3 entries, rst_i pulsed low mid-drain -> all outputs at reset values asynchronously; after release, empty_o=1 and no stale upd_valid_o.
